// File: rtl/eq_pkg.sv
// Shared definitions for the biquad EQ bank.
// Contents: FSM state enum, coefficient tap enum, band/gain constants.
// COEF_ONE is unity in Q2.16, i.e. for the default 18-bit coefficient width.
package eq_pkg;

   localparam int MAX_BANDS  = 8;
   localparam int NUM_TAPS   = 5;
   localparam int GAIN_UNITY = 16;
   localparam int COEF_W_DEF = 18;
   localparam int COEF_ONE   = 1 << (COEF_W_DEF - 2);

   typedef enum logic [1:0] {StIdle, StMac, StWb, StOut} eq_state_e;

   typedef enum logic [2:0] {TapB0, TapB1, TapB2, TapA1, TapA2} eq_tap_e;

endpackage

// File: rtl/effect_eq_biquad_bank_if.sv
// Sample stream and coefficient bus of the biquad EQ bank.
// master: sample source / coefficient writer (drives i_*, reads o_*).
// slave : the EQ bank (reads i_*, drives o_ready, o_data, o_valid).
interface effect_eq_biquad_bank_if #(
   parameter int DATA_W = 16,
   parameter int COEF_W = 18
);
   logic                     i_valid;
   logic                     o_ready;
   logic signed [DATA_W-1:0] i_data;
   logic                     i_enable;
   logic [7:0]               i_gain;
   logic                     i_coef_we;
   logic [5:0]               i_coef_addr;
   logic signed [COEF_W-1:0] i_coef_wdata;
   logic                     i_coef_commit;
   logic signed [DATA_W-1:0] o_data;
   logic                     o_valid;

   modport master (
      output i_valid, i_data, i_enable, i_gain,
      output i_coef_we, i_coef_addr, i_coef_wdata, i_coef_commit,
      input  o_ready, o_data, o_valid
   );

   modport slave (
      input  i_valid, i_data, i_enable, i_gain,
      input  i_coef_we, i_coef_addr, i_coef_wdata, i_coef_commit,
      output o_ready, o_data, o_valid
   );
endinterface

// File: rtl/eq_mac.sv
// Multiply-accumulate unit for one biquad band.
// Ports: i_clk, i_rst (sync, active-high); i_en accumulates i_sample*i_coef,
// i_clr starts a fresh sum, i_sub subtracts the product (feedback taps).
// o_result: accumulator rounded half-up from Q2.(COEF_W-2), saturated to DATA_W.
module eq_mac #(
   parameter int DATA_W = 16,
   parameter int COEF_W = 18,
   parameter int ACC_W  = 48
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_en,
   input  logic                     i_clr,
   input  logic                     i_sub,
   input  logic signed [DATA_W-1:0] i_sample,
   input  logic signed [COEF_W-1:0] i_coef,
   output logic signed [DATA_W-1:0] o_result
);
   localparam int PROD_W = DATA_W + COEF_W;
   localparam logic signed [ACC_W-1:0] RoundK = ACC_W'(64'd1 << (COEF_W - 3));
   localparam logic signed [ACC_W-1:0] MaxV =
      {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] MinV =
      {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  prod_ext, base, acc_d, acc_q, rnd;

   always_comb begin
      prod     = PROD_W'(i_sample) * PROD_W'(i_coef);
      prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
      base     = i_clr ? '0 : acc_q;
      acc_d    = i_sub ? base - prod_ext : base + prod_ext;
      rnd      = (acc_q + RoundK) >>> (COEF_W - 2);
      if (rnd > MaxV)      o_result = MaxV[DATA_W-1:0];
      else if (rnd < MinV) o_result = MinV[DATA_W-1:0];
      else                 o_result = rnd[DATA_W-1:0];
   end

   always_ff @(posedge i_clk) begin
      if (i_rst)     acc_q <= '0;
      else if (i_en) acc_q <= acc_d;
   end
endmodule

// File: rtl/effect_eq_biquad_bank.sv
// Cascade of NUM_BANDS Direct Form I biquads with master output gain.
// Ports: i_clk, i_rst (sync, active-high), bus (slave modport): sample
// handshake i_valid/o_ready, i_data/i_enable/i_gain, coefficient shadow-bank
// writes (i_coef_we/addr/wdata) and commit, result o_data with o_valid strobe.
// Optional macro EQ_GAIN_RAMP_EN: applied gain walks 1 LSB per processed sample
// toward i_gain instead of following it directly.
module effect_eq_biquad_bank
   import eq_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int COEF_W    = 18,
   parameter int NUM_BANDS = 4,
   parameter int ACC_W     = 48
) (
   input logic                    i_clk,
   input logic                    i_rst,
   effect_eq_biquad_bank_if.slave bus
);
   localparam int NUM_COEF = NUM_TAPS * NUM_BANDS;
   localparam int GW       = DATA_W + 9;
   localparam logic [2:0] LastBand = 3'(NUM_BANDS - 1);
   localparam logic signed [COEF_W-1:0] CoefOne = {2'b01, {(COEF_W-2){1'b0}}};
   localparam logic signed [GW-1:0] GMax = {{(GW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [GW-1:0] GMin = {{(GW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   logic signed [COEF_W-1:0] shadow_q [NUM_COEF];
   logic signed [COEF_W-1:0] shadow_d [NUM_COEF];
   logic signed [COEF_W-1:0] active_q [NUM_COEF];
   logic signed [DATA_W-1:0] x1_q [NUM_BANDS];
   logic signed [DATA_W-1:0] x2_q [NUM_BANDS];
   logic signed [DATA_W-1:0] y1_q [NUM_BANDS];
   logic signed [DATA_W-1:0] y2_q [NUM_BANDS];

   eq_state_e                state_q, state_d;
   eq_tap_e                  tap_q;
   logic [2:0]               band_q;
   logic signed [DATA_W-1:0] cur_x_q, o_data_q, mac_sample, mac_y, gain_y;
   logic signed [COEF_W-1:0] mac_coef;
   logic                     en_q, pend_q, o_valid_q, mac_sub, idle;
   logic [7:0]               gain_q;
   logic [5:0]               coef_idx;
   logic signed [GW-1:0]     gprod, grnd;

   assign idle        = (state_q == StIdle);
   assign bus.o_ready = idle;
   assign bus.o_data  = o_data_q;
   assign bus.o_valid = o_valid_q;
   assign coef_idx    = 6'(band_q) * 6'd5 + 6'(tap_q);

   // Shadow bank next value; a write in the commit cycle is part of the commit.
   always_comb begin
      for (int i = 0; i < NUM_COEF; i++) begin
         shadow_d[i] = shadow_q[i];
         if (bus.i_coef_we && bus.i_coef_addr == 6'(i)) shadow_d[i] = bus.i_coef_wdata;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (bus.i_valid) state_d = StMac;
         StMac:   if (tap_q == TapA2) state_d = StWb;
         StWb:    state_d = (band_q == LastBand) ? StOut : StMac;
         StOut:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      mac_coef   = '0;
      mac_sample = cur_x_q;
      mac_sub    = 1'b0;
      for (int i = 0; i < NUM_COEF; i++) begin
         if (coef_idx == 6'(i)) mac_coef = active_q[i];
      end
      for (int b = 0; b < NUM_BANDS; b++) begin
         if (band_q == 3'(b)) begin
            unique case (tap_q)
               TapB1:   mac_sample = x1_q[b];
               TapB2:   mac_sample = x2_q[b];
               TapA1:   begin mac_sample = y1_q[b]; mac_sub = 1'b1; end
               TapA2:   begin mac_sample = y2_q[b]; mac_sub = 1'b1; end
               default: mac_sample = cur_x_q;
            endcase
         end
      end
   end

   eq_mac #(
      .DATA_W (DATA_W),
      .COEF_W (COEF_W),
      .ACC_W  (ACC_W)
   ) u_mac (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_en     (state_q == StMac),
      .i_clr    (tap_q == TapB0),
      .i_sub    (mac_sub),
      .i_sample (mac_sample),
      .i_coef   (mac_coef),
      .o_result (mac_y)
   );

   // Master gain, Q4.4: multiply, round half-up, drop 4 fraction bits, saturate.
   always_comb begin
      gprod = GW'(cur_x_q) * GW'($signed({1'b0, gain_q}));
      grnd  = (gprod + GW'(8)) >>> 4;
      if (grnd > GMax)      gain_y = GMax[DATA_W-1:0];
      else if (grnd < GMin) gain_y = GMin[DATA_W-1:0];
      else                  gain_y = grnd[DATA_W-1:0];
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= StIdle;
         tap_q     <= TapB0;
         band_q    <= '0;
         cur_x_q   <= '0;
         en_q      <= 1'b0;
         pend_q    <= 1'b0;
         gain_q    <= 8'(GAIN_UNITY);
         o_data_q  <= '0;
         o_valid_q <= 1'b0;
         for (int i = 0; i < NUM_COEF; i++) begin
            shadow_q[i] <= (i % NUM_TAPS == 0) ? CoefOne : '0;
            active_q[i] <= (i % NUM_TAPS == 0) ? CoefOne : '0;
         end
         for (int b = 0; b < NUM_BANDS; b++) begin
            x1_q[b] <= '0;
            x2_q[b] <= '0;
            y1_q[b] <= '0;
            y2_q[b] <= '0;
         end
      end else begin
         state_q   <= state_d;
         o_valid_q <= 1'b0;
         shadow_q  <= shadow_d;
         // Active bank only moves while idle so a sample never sees a mixed bank.
         if (idle && (bus.i_coef_commit || pend_q)) begin
            active_q <= shadow_d;
            pend_q   <= 1'b0;
         end else if (bus.i_coef_commit) begin
            pend_q <= 1'b1;
         end
         case (state_q)
            StIdle: begin
               if (bus.i_valid) begin
                  cur_x_q <= bus.i_data;
                  en_q    <= bus.i_enable;
                  tap_q   <= TapB0;
                  band_q  <= '0;
`ifdef EQ_GAIN_RAMP_EN
                  if (bus.i_enable && gain_q < bus.i_gain)      gain_q <= gain_q + 8'd1;
                  else if (bus.i_enable && gain_q > bus.i_gain) gain_q <= gain_q - 8'd1;
`else
                  gain_q <= bus.i_gain;
`endif
               end
            end
            StMac: tap_q <= (tap_q == TapA2) ? TapB0 : eq_tap_e'(tap_q + 3'd1);
            StWb: begin
               // Bypassed samples leave the chain input and all band history untouched.
               if (en_q) cur_x_q <= mac_y;
               for (int b = 0; b < NUM_BANDS; b++) begin
                  if (en_q && band_q == 3'(b)) begin
                     x1_q[b] <= cur_x_q;
                     x2_q[b] <= x1_q[b];
                     y1_q[b] <= mac_y;
                     y2_q[b] <= y1_q[b];
                  end
               end
               band_q <= band_q + 3'd1;
            end
            StOut: begin
               o_data_q  <= en_q ? gain_y : cur_x_q;
               o_valid_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule
